// File: rtl/mem_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// mem_xfer_ctrl
//
// Sequencing controller for the memory-to-memory transfer datapath.
//
// One run does two things:
//   1. Loads DEPTH_A words from a valid-qualified source stream into memory A.
//   2. Moves A into memory B using one of two modes:
//        copy     : B[i] = A[i]                (2 cycles per B word)
//        pair-sum : B[i] = A[2i] + A[2i+1]     (3 cycles per B word)
//
// The controller owns the state register and both address counters. The
// datapath (memories, operand register, B write-data mux) sits outside and is
// steered by wea/web/addr_a/addr_b/acc_ld/acc_add.
//
// Parameters
//   ADDR_W   width of addr_a/addr_b and of the internal counters
//   DEPTH_A  words loaded into A per run; even, 2..2**ADDR_W
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset; forces IDLE, outputs low/zero
//   start     in   begin a run (sampled only in IDLE)
//   mode      in   0 = copy, 1 = pair-sum; latched into mode_r on start
//   abort     in   synchronous cancel, honoured in every state except IDLE
//   in_valid  in   source word present on the A write-data bus
//   in_ready  out  high throughout LOAD
//   wea       out  memory A write enable (in_ready & in_valid)
//   addr_a    out  memory A address (write in LOAD, read in RD0/RD1)
//   web       out  memory B write enable
//   addr_b    out  memory B write address
//   acc_ld    out  datapath captures A read data into the operand register
//   acc_add   out  B write-data mux: 0 = A dout, 1 = operand + A dout
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse on run completion
// -----------------------------------------------------------------------------
module mem_xfer_ctrl #(
   parameter int ADDR_W  = 4,
   parameter int DEPTH_A = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              wea,
   output logic [ADDR_W-1:0] addr_a,
   output logic              web,
   output logic [ADDR_W-1:0] addr_b,
   output logic              acc_ld,
   output logic              acc_add,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RD0  = 3'd2,
      RD1  = 3'd3,
      WR   = 3'd4,
      DONE = 3'd5
   } state_t;

   // Terminal counter values. The last load beat is at DEPTH_A-1; the last
   // B word is DEPTH_A-1 in copy mode and DEPTH_A/2-1 in pair-sum mode.
   localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(DEPTH_A - 1);
   localparam logic [ADDR_W-1:0] LAST_COPY = ADDR_W'(DEPTH_A - 1);
   localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(DEPTH_A / 2 - 1);
   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   cnt_a;
   logic [ADDR_W-1:0]   cnt_a_nxt;
   logic [ADDR_W-1:0]   cnt_b;
   logic [ADDR_W-1:0]   cnt_b_nxt;
   logic                mode_r;
   logic                mode_r_nxt;
   logic                last_b;

   // Last B word depends on the mode latched at start, never the live input.
   assign last_b = (cnt_b == (mode_r ? LAST_PAIR : LAST_COPY));

   // A write enable is the only output not taken from a register: a load beat
   // must be accepted in the same cycle the source presents it.
   assign wea = in_ready & in_valid;

   // --------------------------------------------------------------------------
   // Next-state and next-counter logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first so no path leaves
      // it unassigned; otherwise synthesis would infer a latch to hold it.
      state_nxt  = state;
      cnt_a_nxt  = cnt_a;
      cnt_b_nxt  = cnt_b;
      mode_r_nxt = mode_r;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt  = LOAD;
               mode_r_nxt = mode;
               cnt_a_nxt  = '0;
               cnt_b_nxt  = '0;
            end
         end

         LOAD: begin
            // Idle source cycles hold the count, so addresses never skip.
            if (in_valid) begin
               if (cnt_a == LAST_A) begin
                  state_nxt = RD0;
                  cnt_a_nxt = '0;
               end else begin
                  cnt_a_nxt = cnt_a + ONE;
               end
            end
         end

         RD0: begin
            // Read A[cnt_a]. In pair mode the next read (odd word) follows
            // immediately while the even word is captured in RD1.
            if (mode_r) begin
               state_nxt = RD1;
               cnt_a_nxt = cnt_a + ONE;
            end else begin
               state_nxt = WR;
            end
         end

         RD1: begin
            state_nxt = WR;
         end

         WR: begin
            if (last_b) begin
               // Clear here so the counters never wrap past the last address.
               state_nxt = DONE;
               cnt_a_nxt = '0;
               cnt_b_nxt = '0;
            end else begin
               state_nxt = RD0;
               cnt_a_nxt = cnt_a + ONE;
               cnt_b_nxt = cnt_b + ONE;
            end
         end

         DONE: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
            cnt_a_nxt = '0;
            cnt_b_nxt = '0;
         end
      endcase

      // Abort overrides every transition outside IDLE. In IDLE it is ignored,
      // so a simultaneous start still launches a run.
      if (abort && (state != IDLE)) begin
         state_nxt = IDLE;
         cnt_a_nxt = '0;
         cnt_b_nxt = '0;
      end
   end

   // --------------------------------------------------------------------------
   // State, counters and registered outputs
   //
   // Outputs are registered from the next-state values so each one is a clean
   // flop output that matches the state it belongs to in the same cycle.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt_a    <= '0;
         cnt_b    <= '0;
         mode_r   <= 1'b0;
         in_ready <= 1'b0;
         addr_a   <= '0;
         web      <= 1'b0;
         addr_b   <= '0;
         acc_ld   <= 1'b0;
         acc_add  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state    <= state_nxt;
         cnt_a    <= cnt_a_nxt;
         cnt_b    <= cnt_b_nxt;
         mode_r   <= mode_r_nxt;
         in_ready <= (state_nxt == LOAD);
         // Addresses read as zero whenever their counter is not in use.
         addr_a   <= (state_nxt inside {LOAD, RD0, RD1}) ? cnt_a_nxt : '0;
         web      <= (state_nxt == WR);
         addr_b   <= (state_nxt == WR) ? cnt_b_nxt : '0;
         acc_ld   <= (state_nxt == RD1);
         acc_add  <= (state_nxt == WR) && mode_r_nxt;
         busy     <= (state_nxt != IDLE);
         done     <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_xfer_ctrl
//
// Self-checking bench for mem_xfer_ctrl (ADDR_W=4, DEPTH_A=8). A small model
// of the external datapath (memory A, synchronous read register, operand
// register, B write mux, memory B) sits next to the DUT. Each test fills a
// per-cycle stimulus table, pushes the events it expects into a scoreboard
// queue, runs, and compares the observed event queue against it.
// Cycle 0 is the cycle in which start is first driven.
// -----------------------------------------------------------------------------
module tb_mem_xfer_ctrl;

   localparam int ADDR_W  = 4;
   localparam int DEPTH_A = 8;
   localparam int MAXC    = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              mode;
   logic              abort;
   logic              in_valid;
   logic              in_ready;
   logic              wea;
   logic [ADDR_W-1:0] addr_a;
   logic              web;
   logic [ADDR_W-1:0] addr_b;
   logic              acc_ld;
   logic              acc_add;
   logic              busy;
   logic              done;

   mem_xfer_ctrl #(.ADDR_W(ADDR_W), .DEPTH_A(DEPTH_A)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mode     (mode),
      .abort    (abort),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .wea      (wea),
      .addr_a   (addr_a),
      .web      (web),
      .addr_b   (addr_b),
      .acc_ld   (acc_ld),
      .acc_add  (acc_add),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // ---------------- datapath model ----------------
   logic [7:0] din;
   logic [7:0] mem_a [2**ADDR_W];
   logic [7:0] mem_b [2**ADDR_W];
   logic [7:0] a_dout;
   logic [7:0] opnd;
   logic [7:0] bdata;

   assign bdata = acc_add ? 8'(opnd + a_dout) : a_dout;

   always @(posedge clk) begin
      if (wea) mem_a[addr_a] <= din;
      a_dout <= mem_a[addr_a];
      if (acc_ld) opnd <= a_dout;
      if (web) mem_b[addr_b] <= bdata;
   end

   // ---------------- scoreboard ----------------
   // kind: 0 = A write, 1 = B write, 2 = operand load
   typedef struct packed {
      logic [1:0]        kind;
      int                cyc;
      logic [ADDR_W-1:0] addr;
      logic              add;
      logic [7:0]        data;
   } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];
   int  obs_done[$];
   int  busy_cnt;
   int  busy_first;
   int  busy_last;
   int  n_cmp = 0;
   int  n_bad = 0;

   logic       st_v [MAXC];
   logic       md_v [MAXC];
   logic       ab_v [MAXC];
   logic       iv_v [MAXC];
   logic [7:0] load_data [DEPTH_A];
   int         beat;

   task automatic clear_stim();
      for (int i = 0; i < MAXC; i++) begin
         st_v[i] = 1'b0;
         md_v[i] = 1'b0;
         ab_v[i] = 1'b0;
         iv_v[i] = 1'b1;
      end
      exp_q.delete();
      obs_q.delete();
      obs_done.delete();
      busy_cnt   = 0;
      busy_first = -1;
      busy_last  = -1;
      beat       = 0;
   endtask

   // Drive ncyc cycles from the tables and record what the DUT does.
   // Entered and left at posedge+1.
   task automatic run(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         start    = st_v[c];
         mode     = md_v[c];
         abort    = ab_v[c];
         in_valid = iv_v[c];
         din      = (beat < DEPTH_A) ? load_data[beat] : 8'h00;
         #1;
         if (wea) begin
            obs_q.push_back('{2'd0, c, addr_a, 1'b0, din});
            beat++;
         end
         if (acc_ld) obs_q.push_back('{2'd2, c, '0, 1'b0, 8'h00});
         if (web)    obs_q.push_back('{2'd1, c, addr_b, acc_add, bdata});
         if (done)   obs_done.push_back(c);
         if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = c;
            busy_last = c;
         end
         @(posedge clk);
         #1;
      end
      start    = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
   endtask

   // Expected A writes for a load whose k-th beat lands in cycle cyc[k].
   task automatic push_loads(input int first, input int stride);
      for (int k = 0; k < DEPTH_A; k++)
         exp_q.push_back('{2'd0, first + stride * k, ADDR_W'(k), 1'b0, load_data[k]});
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_cmp++;
      if ({in_ready, wea, web, acc_ld, acc_add, busy, done, addr_a, addr_b} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got rdy=%b wea=%b web=%b ld=%b add=%b busy=%b done=%b aa=%0d ab=%0d, want all 0",
                  in_ready, wea, web, acc_ld, acc_add, busy, done, addr_a, addr_b);
      end
   endtask

   task automatic test_copy();
      clear_stim();
      for (int k = 0; k < DEPTH_A; k++) load_data[k] = 8'(8'h10 + 7 * k);
      st_v[0] = 1'b1;
      push_loads(1, 1);
      for (int k = 0; k < DEPTH_A; k++)
         exp_q.push_back('{2'd1, 10 + 2 * k, ADDR_W'(k), 1'b0, load_data[k]});
      run(30);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL copy_events: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL copy_ev%0d: got k=%0d cyc=%0d a=%0d add=%b d=%0d, want k=%0d cyc=%0d a=%0d add=%b d=%0d", i,
                     obs_q[i].kind, obs_q[i].cyc, obs_q[i].addr, obs_q[i].add, obs_q[i].data,
                     exp_q[i].kind, exp_q[i].cyc, exp_q[i].addr, exp_q[i].add, exp_q[i].data);
         end
      end
      n_cmp++;
      if (obs_done.size() != 1 || obs_done[0] != 25) begin
         n_bad++;
         $display("FAIL copy_done: got %0d pulses first at %0d, want 1 at 25", obs_done.size(), obs_done[0]);
      end
      n_cmp++;
      if (busy_cnt != 25 || busy_first != 1 || busy_last != 25) begin
         n_bad++;
         $display("FAIL copy_busy: got %0d cycles %0d..%0d, want 25 cycles 1..25", busy_cnt, busy_first, busy_last);
      end
      for (int k = 0; k < DEPTH_A; k++) begin
         n_cmp++;
         if (mem_b[k] !== load_data[k]) begin
            n_bad++;
            $display("FAIL copy_memb%0d: got %0d, want %0d", k, mem_b[k], load_data[k]);
         end
      end
   endtask

   task automatic test_pair();
      clear_stim();
      for (int k = 0; k < DEPTH_A; k++) load_data[k] = 8'(k + 1);
      st_v[0] = 1'b1;
      md_v[0] = 1'b1;
      push_loads(1, 1);
      for (int k = 0; k < DEPTH_A / 2; k++) begin
         exp_q.push_back('{2'd2, 10 + 3 * k, '0, 1'b0, 8'h00});
         exp_q.push_back('{2'd1, 11 + 3 * k, ADDR_W'(k), 1'b1, 8'(4 * k + 3)});
      end
      run(28);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL pair_events: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL pair_ev%0d: got k=%0d cyc=%0d a=%0d add=%b d=%0d, want k=%0d cyc=%0d a=%0d add=%b d=%0d", i,
                     obs_q[i].kind, obs_q[i].cyc, obs_q[i].addr, obs_q[i].add, obs_q[i].data,
                     exp_q[i].kind, exp_q[i].cyc, exp_q[i].addr, exp_q[i].add, exp_q[i].data);
         end
      end
      n_cmp++;
      if (obs_done.size() != 1 || obs_done[0] != 21) begin
         n_bad++;
         $display("FAIL pair_done: got %0d pulses first at %0d, want 1 at 21", obs_done.size(), obs_done[0]);
      end
      n_cmp++;
      if (busy_cnt != 21 || busy_last != 21) begin
         n_bad++;
         $display("FAIL pair_busy: got %0d cycles last %0d, want 21 cycles last 21", busy_cnt, busy_last);
      end
      for (int k = 0; k < DEPTH_A / 2; k++) begin
         n_cmp++;
         if (mem_b[k] !== 8'(4 * k + 3)) begin
            n_bad++;
            $display("FAIL pair_memb%0d: got %0d, want %0d", k, mem_b[k], 4 * k + 3);
         end
      end
   endtask

   task automatic test_valid_gaps();
      clear_stim();
      for (int k = 0; k < DEPTH_A; k++) load_data[k] = 8'(8'hA0 + k);
      st_v[0] = 1'b1;
      for (int c = 0; c < MAXC; c++) iv_v[c] = (c % 2 == 1);
      push_loads(1, 2);
      for (int k = 0; k < DEPTH_A; k++)
         exp_q.push_back('{2'd1, 17 + 2 * k, ADDR_W'(k), 1'b0, load_data[k]});
      run(40);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL gaps_events: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL gaps_ev%0d: got k=%0d cyc=%0d a=%0d d=%0d, want k=%0d cyc=%0d a=%0d d=%0d", i,
                     obs_q[i].kind, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data,
                     exp_q[i].kind, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
         end
      end
      n_cmp++;
      if (obs_done.size() != 1 || obs_done[0] != 32) begin
         n_bad++;
         $display("FAIL gaps_done: got %0d pulses first at %0d, want 1 at 32", obs_done.size(), obs_done[0]);
      end
   endtask

   task automatic test_start_mode_busy();
      clear_stim();
      for (int k = 0; k < DEPTH_A; k++) load_data[k] = 8'(8'hF0 - 5 * k);
      st_v[0] = 1'b1;
      st_v[5] = 1'b1;
      for (int c = 12; c < MAXC; c++) md_v[c] = 1'b1;
      push_loads(1, 1);
      for (int k = 0; k < DEPTH_A; k++)
         exp_q.push_back('{2'd1, 10 + 2 * k, ADDR_W'(k), 1'b0, load_data[k]});
      run(30);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL busyin_events: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL busyin_ev%0d: got k=%0d cyc=%0d a=%0d add=%b d=%0d, want k=%0d cyc=%0d a=%0d add=%b d=%0d", i,
                     obs_q[i].kind, obs_q[i].cyc, obs_q[i].addr, obs_q[i].add, obs_q[i].data,
                     exp_q[i].kind, exp_q[i].cyc, exp_q[i].addr, exp_q[i].add, exp_q[i].data);
         end
      end
      n_cmp++;
      if (obs_done.size() != 1 || obs_done[0] != 25) begin
         n_bad++;
         $display("FAIL busyin_done: got %0d pulses first at %0d, want 1 at 25", obs_done.size(), obs_done[0]);
      end
   endtask

   task automatic test_abort();
      clear_stim();
      for (int k = 0; k < DEPTH_A; k++) load_data[k] = 8'(8'h30 + 3 * k);
      st_v[0]  = 1'b1;
      ab_v[14] = 1'b1;
      push_loads(1, 1);
      for (int k = 0; k < 3; k++)
         exp_q.push_back('{2'd1, 10 + 2 * k, ADDR_W'(k), 1'b0, load_data[k]});
      run(20);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL abort_events: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL abort_ev%0d: got k=%0d cyc=%0d a=%0d d=%0d, want k=%0d cyc=%0d a=%0d d=%0d", i,
                     obs_q[i].kind, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data,
                     exp_q[i].kind, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
         end
      end
      n_cmp++;
      if (obs_done.size() != 0 || busy_cnt != 14 || busy_last != 14) begin
         n_bad++;
         $display("FAIL abort_idle: got done=%0d busy %0d cycles last %0d, want done=0 busy 14 cycles last 14",
                  obs_done.size(), busy_cnt, busy_last);
      end
      // A fresh run after the abort must start again from address 0.
      clear_stim();
      for (int k = 0; k < DEPTH_A; k++) load_data[k] = 8'(8'h60 + 9 * k);
      st_v[0] = 1'b1;
      push_loads(1, 1);
      for (int k = 0; k < DEPTH_A; k++)
         exp_q.push_back('{2'd1, 10 + 2 * k, ADDR_W'(k), 1'b0, load_data[k]});
      run(30);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL rerun_events: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL rerun_ev%0d: got k=%0d cyc=%0d a=%0d d=%0d, want k=%0d cyc=%0d a=%0d d=%0d", i,
                     obs_q[i].kind, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data,
                     exp_q[i].kind, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
         end
      end
      n_cmp++;
      if (obs_done.size() != 1 || obs_done[0] != 25) begin
         n_bad++;
         $display("FAIL rerun_done: got %0d pulses first at %0d, want 1 at 25", obs_done.size(), obs_done[0]);
      end
   endtask

   task automatic test_async_reset();
      clear_stim();
      for (int k = 0; k < DEPTH_A; k++) load_data[k] = 8'(k);
      st_v[0] = 1'b1;
      run(14);               // now in cycle 14: WR of word 2
      n_cmp++;
      if ({web, busy, addr_b} !== {1'b1, 1'b1, ADDR_W'(2)}) begin
         n_bad++;
         $display("FAIL arst_pre: got web=%b busy=%b addr_b=%0d, want web=1 busy=1 addr_b=2", web, busy, addr_b);
      end
      #2;
      rst = 1'b1;
      #1;                    // still well before the next rising edge
      n_cmp++;
      if ({web, busy, addr_b, in_ready, done} !== '0) begin
         n_bad++;
         $display("FAIL arst_drop: got web=%b busy=%b addr_b=%0d rdy=%b done=%b, want all 0",
                  web, busy, addr_b, in_ready, done);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, web, in_ready} !== 4'b0000) begin
         n_bad++;
         $display("FAIL arst_idle: got busy=%b done=%b web=%b rdy=%b, want 0000", busy, done, web, in_ready);
      end
      // From IDLE a start must enter LOAD at address 0 on the next cycle.
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_cmp++;
      if ({in_ready, busy, addr_a} !== {1'b1, 1'b1, ADDR_W'(0)}) begin
         n_bad++;
         $display("FAIL arst_restart: got rdy=%b busy=%b addr_a=%0d, want rdy=1 busy=1 addr_a=0", in_ready, busy, addr_a);
      end
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      mode     = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
      din      = 8'h00;
      opnd     = 8'h55;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      test_copy();
      test_pair();
      test_valid_gaps();
      test_start_mode_busy();
      test_abort();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_xfer_ctrl.md
Name: mem_xfer_ctrl

Overview:
Sequencing controller for the memory-to-memory transfer datapath. It loads DEPTH_A words from an external valid-qualified stream into memory A. It then moves the contents of A into memory B, in one of two modes: straight copy, or pair-sum (B[i] = A[2i] + A[2i+1]). Unlike the fixed 5-bit decoded controller, it owns its own state register and address counters, is parametrised in depth and address width, and provides start/done/abort handshakes.

Parameters:
ADDR_W, 4, width of addr_a/addr_b and internal counters
DEPTH_A, 8, words loaded into A per run; even, 2..2**ADDR_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high; forces IDLE and all outputs low/zero
start  in  1  begin a run; sampled only in IDLE
mode  in  1  0 = copy, 1 = pair-sum; latched into mode_r on accepted start
abort  in  1  synchronous cancel; honoured in any non-IDLE state
in_valid  in  1  source word present on A write-data bus
in_ready  out  1  controller accepting load words (high throughout LOAD)
wea  out  1  memory A write enable
addr_a  out  ADDR_W  memory A address (write in LOAD, read in transfer)
web  out  1  memory B write enable
addr_b  out  ADDR_W  memory B write address
acc_ld  out  1  datapath captures A read data into operand register
acc_add  out  1  B write-data mux: 0 = A dout, 1 = operand reg + A dout
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on run completion

Behaviour:
- Reset: state=IDLE. in_ready, wea, web, acc_ld, acc_add, busy, done = 0. addr_a, addr_b, cnt_a, cnt_b = 0. mode_r = 0. Applies immediately, including mid-run; no partial done.
- States: IDLE, LOAD, RD0, RD1, WR, DONE. Outputs are decoded from the registered state, except wea = in_ready & in_valid.
- IDLE: start=1 -> LOAD next cycle; latch mode_r; clear counters.
- LOAD: in_ready=1, addr_a=cnt_a. Each cycle with in_valid=1: wea=1 and cnt_a++. Cycles with in_valid=0 write nothing and hold the count. The write at cnt_a=DEPTH_A-1 -> RD0 and clears cnt_a.
- RD0: addr_a=cnt_a, synchronous read, data valid next cycle. mode_r=0 -> WR. mode_r=1 -> RD1, with cnt_a++.
- RD1 (pair only): acc_ld=1 (captures A[2i]); addr_a=cnt_a (=2i+1) -> WR.
- WR: web=1, addr_b=cnt_b, acc_add=mode_r. cnt_a++ and cnt_b++.
  - Last word (cnt_b = DEPTH_A-1 in copy, DEPTH_A/2-1 in pair) -> DONE.
  - Otherwise -> RD0.
- DONE: done=1 for one cycle, busy=1 -> IDLE.
- addr_a/addr_b are 0 whenever their counter is inactive. Counters never wrap within a run (DEPTH_A ≤ 2**ADDR_W).
- Throughput: copy = 2 cycles per B word; pair = 3 cycles per B word. Sum width = data width; overflow truncates in the datapath, not here.
- start while busy: ignored; mode changes mid-run are ignored (mode_r holds).
- abort=1 in LOAD/RD0/RD1/WR/DONE: next state IDLE, counters cleared, no done pulse. Any wea/web asserted in the abort cycle still completes.
- abort and start together in IDLE: start wins; abort is ignored in IDLE.
- Latency, continuous in_valid, start sampled at cycle 0:
  - Copy: LOAD cycles 1..DEPTH_A; done at cycle 2*DEPTH_A+DEPTH_A+1.
  - Pair: done at cycle DEPTH_A+3*(DEPTH_A/2)+1.

Test Plan:
1. DEPTH_A=8, copy, start@0, in_valid always 1 -> wea cycles 1..8 with addr_a 0..7; web at cycles 10,12,..,24 with addr_b 0..7; done pulse cycle 25; busy high cycles 1..25.
2. DEPTH_A=8, pair, A loaded 1..8 -> acc_ld at 10,13,16,19; web at 11,14,17,20 with addr_b 0..3, acc_add=1; B = 3,7,11,15; done cycle 21.
3. in_valid toggling 1,0,1,0 in LOAD -> wea only on valid cycles; addr_a steps 0..7 without skips; transfer starts the cycle after the 8th beat.
4. start pulsed at cycle 5 and mode flipped at cycle 12 during a copy run -> no restart; run stays copy; single done at cycle 25.
5. abort at cycle 14 of a copy run -> IDLE at 15; no done; busy=0; a fresh start then completes a full run from addr 0.
6. rst asserted asynchronously mid-WR -> web, busy, addr_b drop to 0 before the next clock edge; state IDLE after rst releases.
